// File: rtl/tpu_spi_tx.sv
// Word FIFO used to queue outgoing result words ahead of the serial shifter.
// Latency: a written word is visible on rd_dat the next cycle.
// Backpressure: wr_rdy drops while full; writes while full are discarded.
module tpu_spi_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign wr_rdy = !full;
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// Source-synchronous word transmitter returning TPU results to the host.
// Latency: word on data_out one cycle after it is popped, rising clk_out HALF cycles later.
// Backpressure: in_ready = FIFO not full; an empty FIFO mid-frame parks clk_out low (STALL).
module tpu_spi_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  clk_out,
  output logic                  sel_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    STALL = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  clk_nxt;
  logic                  sel_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  cur_last;
  logic                  last_nxt;
  logic                  done_nxt;
  logic [7:0]            fcnt_nxt;

  logic                  pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rd_dat;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_last;
  logic                  half_end;
  logic                  gap_end;

  tpu_spi_tx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_dat ({in_last, in_data}),
    .wr_rdy (in_ready),
    .rd_en  (pop),
    .rd_dat (fifo_rd_dat),
    .empty  (fifo_empty)
  );

  assign fifo_last = fifo_rd_dat[DATA_WIDTH];
  assign fifo_data = fifo_rd_dat[DATA_WIDTH-1:0];
  assign half_end  = (cnt == HALF_END);
  assign gap_end   = (cnt == GAP_END);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_out    <= 1'b0;
      sel_out    <= 1'b0;
      data_out   <= '0;
      cur_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clk_out    <= clk_nxt;
      sel_out    <= sel_nxt;
      data_out   <= data_nxt;
      cur_last   <= last_nxt;
      frame_done <= done_nxt;
      frame_cnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    clk_nxt   = clk_out;
    sel_nxt   = sel_out;
    data_nxt  = data_out;
    last_nxt  = cur_last;
    done_nxt  = 1'b0;
    fcnt_nxt  = frame_cnt;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          sel_nxt   = 1'b1;
          clk_nxt   = 1'b0;
          data_nxt  = fifo_data;
          last_nxt  = fifo_last;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (half_end) begin
          clk_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (half_end) begin
          clk_nxt = 1'b0;
          cnt_nxt = '0;
          if (cur_last) begin
            state_nxt = HOLD;
          end else if (!fifo_empty) begin
            // Next word changes together with the falling edge, giving a full low phase of setup.
            pop       = 1'b1;
            data_nxt  = fifo_data;
            last_nxt  = fifo_last;
            state_nxt = LOW;
          end else begin
            state_nxt = STALL;
          end
        end
      end
      STALL: begin
        cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_nxt  = fifo_data;
          last_nxt  = fifo_last;
          state_nxt = LOW;
        end
      end
      HOLD: begin
        if (half_end) begin
          sel_nxt   = 1'b0;
          data_nxt  = '0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
          fcnt_nxt  = frame_cnt + 8'd1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_end) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        clk_nxt   = 1'b0;
        sel_nxt   = 1'b0;
        data_nxt  = '0;
        last_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_spi_tx.sv
// Scoreboard bench for tpu_spi_tx: words queued at push time, compared at each clk_out rising edge.
module tb_tpu_spi_tx;
  localparam int DW      = 8;
  localparam int CLK_DIV = 4;
  localparam int HALF    = CLK_DIV / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          clk_out;
  logic          sel_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;

  tpu_spi_tx #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .clk_out    (clk_out),
    .sel_out    (sel_out),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  int            len_q[$];
  int            nw_q[$];
  int            nw = 0;
  int            exp_fc = 0;
  bit            no_len = 0;

  // Monitor state
  logic          prev_clk = 0;
  logic          prev_sel = 0;
  logic [DW-1:0] prev_data = '0;
  int            sel_len = 0;
  int            low_len = 0;
  int            edges = 0;
  int            stab = 0;
  bit            had_frame = 0;
  int            total_rises = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_clk  = 0;
      prev_sel  = 0;
      prev_data = '0;
      sel_len   = 0;
      low_len   = 0;
      edges     = 0;
      stab      = 0;
      had_frame = 0;
    end else begin
      if (data_out != prev_data) stab = 0;
      else stab++;
      if (clk_out && !prev_clk) begin
        total_rises++;
        chk("rise_with_sel", sel_out, 1);
        chk("setup_half", (stab >= HALF), 1);
        if (exp_q.size() == 0) chk("sb_nonempty", exp_q.size(), 1);
        else chk("sb_data", data_out, exp_q.pop_front());
        edges++;
      end
      if (!sel_out) chk("data_idle_zero", data_out, 0);
      if (sel_out && !prev_sel && had_frame) chk("gap_min", (low_len >= CLK_DIV), 1);
      if (sel_out) begin
        sel_len++;
        low_len = 0;
      end else begin
        low_len++;
      end
      if (prev_sel && !sel_out) begin
        chk("done_at_end", frame_done, 1);
        if (len_q.size() == 0) begin
          chk("frame_expected", len_q.size(), 1);
        end else begin
          int l;
          int n;
          l = len_q.pop_front();
          n = nw_q.pop_front();
          if (l >= 0) chk("sel_len", sel_len, l);
          chk("edges", edges, n);
        end
        sel_len   = 0;
        edges     = 0;
        had_frame = 1;
      end else if (frame_done) begin
        chk("done_spurious", frame_done, 0);
      end
      prev_clk  = clk_out;
      prev_sel  = sel_out;
      prev_data = data_out;
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic l, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) begin
      exp_q.push_back(d);
      nw++;
      if (l) begin
        nw_q.push_back(nw);
        len_q.push_back(no_len ? -1 : nw * CLK_DIV + HALF);
        nw = 0;
        exp_fc++;
      end
    end
  endtask

  task automatic push_wait(input logic [DW-1:0] d, input logic l);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      push(d, l, ok);
      if (ok) break;
    end
    chk("push_accept", ok, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      if (!busy) break;
    end
    #1;
    chk("reach_idle", busy, 0);
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    exp_q.delete();
    len_q.delete();
    nw_q.delete();
    nw     = 0;
    exp_fc = 0;
  endtask

  initial begin
    bit            ok;
    int            cnt_hi;
    int            base;
    int            acc;
    bit            saw_full;
    logic [DW-1:0] d;

    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    assert_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and quiet idle line
    @(negedge clk);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_sel_out", sel_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    cnt_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clk_out || sel_out) cnt_hi++;
    end
    chk("idle_quiet", cnt_hi, 0);
    @(posedge clk);
    #1;

    // Three-word frame back to back
    push(8'hA1, 0, ok);
    push(8'hB2, 0, ok);
    push(8'hC3, 1, ok);
    wait_idle();
    chk("fc_after_3word", frame_cnt, exp_fc);

    // Underflow stall mid-frame
    base = total_rises;
    push(8'h11, 0, ok);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_clk_low", clk_out, 0);
    chk("stall_sel_high", sel_out, 1);
    chk("stall_data_hold", data_out, 8'h11);
    chk("stall_one_rise", total_rises - base, 1);
    @(posedge clk);
    #1;
    no_len = 1;
    push(8'h22, 1, ok);
    no_len = 0;
    wait_idle();
    chk("stall_total_rises", total_rises - base, 2);
    chk("fc_after_stall", frame_cnt, exp_fc);

    // Fill the FIFO until it refuses; the refused word must never appear
    d        = 8'h40;
    acc      = 0;
    saw_full = 0;
    for (int i = 0; i < 60; i++) begin
      push(d, 0, ok);
      if (ok) begin
        d = d + 8'd1;
        acc++;
      end else begin
        saw_full = 1;
        break;
      end
    end
    chk("fill_full_seen", saw_full, 1);
    chk("fill_acc_ge16", (acc >= 16), 1);
    push_wait(8'hFF, 1);
    wait_idle();
    chk("fc_after_fill", frame_cnt, exp_fc);

    // Two queued single-word frames
    push(8'h5A, 1, ok);
    push(8'h3C, 1, ok);
    wait_idle();
    chk("fc_after_two", frame_cnt, exp_fc);

    // Reset mid-frame after the second rising edge
    push(8'h01, 0, ok);
    push(8'h02, 0, ok);
    push(8'h03, 1, ok);
    base = total_rises;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (total_rises - base >= 2) break;
    end
    chk("midframe_two_rises", total_rises - base, 2);
    #1;
    assert_reset();
    #1;
    chk("mrst_clk_out", clk_out, 0);
    chk("mrst_sel_out", sel_out, 0);
    chk("mrst_data_out", data_out, 0);
    chk("mrst_frame_cnt", frame_cnt, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_post_busy", busy, 0);
    chk("mrst_post_sel", sel_out, 0);
    @(posedge clk);
    #1;
    push(8'h77, 1, ok);
    wait_idle();
    chk("fc_after_mrst", frame_cnt, 1);

    // frame_cnt wrap
    @(posedge clk);
    #1;
    assert_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 255; i++) push_wait(8'(i), 1);
    wait_idle();
    chk("fc_255", frame_cnt, 255);
    push_wait(8'hE7, 1);
    wait_idle();
    chk("fc_wrap", frame_cnt, 0);

    repeat (5) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("frames_drained", len_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
